// File: rtl/fb_pixel_sink.sv
// fb_pixel_sink: clips renderer pixels, buffers them in a FWFT FIFO and writes them to the framebuffer.
// Define FB_SINK_TRANSPARENT_EN to also discard pixels whose colour equals TRANSP_IDX.
module fb_pixel_sink #(
    parameter int CORDW = 16,
    parameter int CIDXW = 4,
    parameter int FB_WIDTH = 320,
    parameter int FB_HEIGHT = 180,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDRW = $clog2(FB_WIDTH * FB_HEIGHT),
    parameter logic [CIDXW-1:0] TRANSP_IDX = 'hF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [CORDW-1:0] x,
    input  logic signed [CORDW-1:0] y,
    input  logic [CIDXW-1:0]        cidx,
    input  logic                    drawing,
    input  logic                    draw_done,
    output logic                    oe,
    output logic                    fb_we,
    output logic [ADDRW-1:0]        fb_addr,
    output logic [CIDXW-1:0]        fb_cidx,
    input  logic                    fb_ready,
    output logic                    busy,
    output logic                    flush_done,
    output logic [15:0]             clip_cnt
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic signed [CORDW-1:0] W_S = CORDW'(FB_WIDTH);
    localparam logic signed [CORDW-1:0] H_S = CORDW'(FB_HEIGHT);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t            state_q;
    logic              draw_done_q, s1_valid_q, busy_q, flush_done_q;
    logic [ADDRW-1:0]  s1_addr_q;
    logic [CIDXW-1:0]  s1_cidx_q;
    logic [ADDRW-1:0]  mem_addr [FIFO_DEPTH];
    logic [CIDXW-1:0]  mem_cidx [FIFO_DEPTH];
    logic [PW-1:0]     wr_q, rd_q;
    logic [CW-1:0]     cnt_q;
    logic [15:0]       clip_cnt_q, clip_cnt_d, clip_base;
    logic              in_bounds, transp, accept, keep, clip, rise, push, pop, leave_idle, drained;

`ifdef FB_SINK_TRANSPARENT_EN
    assign transp = cidx == TRANSP_IDX;
`else
    assign transp = 1'b0;
`endif

    always_comb begin
        in_bounds  = !x[CORDW-1] && x < W_S && !y[CORDW-1] && y < H_S;
        // Keep two slots of headroom: one for the pixel in stage 1, one for this cycle's accept.
        oe         = rst_n && (({1'b0, cnt_q} + (CW+1)'(s1_valid_q)) < (CW+1)'(FIFO_DEPTH - 1));
        accept     = drawing && oe;
        keep       = accept && in_bounds && !transp;
        clip       = accept && !in_bounds;
        rise       = draw_done && !draw_done_q;
        fb_we      = cnt_q != '0;
        fb_addr    = fb_we ? mem_addr[rd_q] : '0;
        fb_cidx    = fb_we ? mem_cidx[rd_q] : '0;
        push       = s1_valid_q;
        pop        = fb_we && fb_ready;
        leave_idle = state_q == IDLE && (rise || accept);
        drained    = !s1_valid_q && cnt_q == '0 && !keep;
        clip_base  = leave_idle ? 16'h0 : clip_cnt_q;
        clip_cnt_d = clip_base + 16'((clip && clip_base != 16'hFFFF) ? 1 : 0);
    end

    assign busy       = busy_q;
    assign flush_done = flush_done_q;
    assign clip_cnt   = clip_cnt_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_q] <= s1_addr_q;
            mem_cidx[wr_q] <= s1_cidx_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            flush_done_q <= 1'b0;
            draw_done_q  <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_addr_q    <= '0;
            s1_cidx_q    <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            clip_cnt_q   <= '0;
        end else begin
            draw_done_q  <= draw_done;
            s1_valid_q   <= keep;
            if (keep) begin
                s1_addr_q <= ADDRW'(int'(y) * FB_WIDTH + int'(x));
                s1_cidx_q <= cidx;
            end
            wr_q         <= wr_q + PW'(push);
            rd_q         <= rd_q + PW'(pop);
            cnt_q        <= cnt_q + CW'(push) - CW'(pop);
            clip_cnt_q   <= clip_cnt_d;
            flush_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= FLUSH;
                        busy_q  <= 1'b1;
                    end else if (accept) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: if (rise) state_q <= FLUSH;
                default: begin
                    if (drained) begin
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        flush_done_q <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fb_pixel_sink.sv
// tb_fb_pixel_sink: directed scenarios plus random traffic checked against a queue-based model.
module tb_fb_pixel_sink;
    localparam int ADDRW = 16;
    localparam int DEPTH = 8;

    logic clk = 1'b0, rst_n = 1'b0;
    logic signed [15:0] x = '0, y = '0;
    logic [3:0] cidx = '0;
    logic drawing = 1'b0, draw_done = 1'b0, fb_ready = 1'b0;
    logic oe, fb_we, busy, flush_done;
    logic [ADDRW-1:0] fb_addr;
    logic [3:0] fb_cidx;
    logic [15:0] clip_cnt;

    always #5 clk = ~clk;

    fb_pixel_sink dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .cidx(cidx), .drawing(drawing),
        .draw_done(draw_done), .oe(oe), .fb_we(fb_we), .fb_addr(fb_addr),
        .fb_cidx(fb_cidx), .fb_ready(fb_ready), .busy(busy), .flush_done(flush_done),
        .clip_cnt(clip_cnt)
    );

    int checks = 0, passes = 0;

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct {int a; int c; int st;} pix_t;
    pix_t q[$];
    int cyc = 0, m_state = 0, m_clip = 0;
    bit m_busy = 0, m_fd = 0, dd_prev = 0;
    int dut_wr = 0, dut_acc = 0, dut_last = 0;

    function automatic bit m_oe();
        return rst_n && q.size() < DEPTH - 1;
    endfunction

    function automatic bit m_we();
        return q.size() > 0 && q[0].st + 2 <= cyc;
    endfunction

    // Pending pixels in accept order; the head becomes writable two edges after its accept.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete();
            m_state = 0; m_busy = 0; m_fd = 0; m_clip = 0; dd_prev = 0;
        end else begin
            automatic bit acc  = drawing && m_oe();
            automatic bit inb  = x >= 0 && x < 320 && y >= 0 && y < 180;
`ifdef FB_SINK_TRANSPARENT_EN
            automatic bit tr   = cidx == 4'hF;
`else
            automatic bit tr   = 1'b0;
`endif
            automatic bit keep = acc && inb && !tr;
            automatic bit rise = draw_done && !dd_prev;
            automatic bit wr   = m_we() && fb_ready;
            automatic bit empty = q.size() == 0;
            m_fd = 0;
            if (m_state == 0 && (rise || acc)) begin
                m_state = rise ? 2 : 1; m_busy = 1; m_clip = 0;
            end else if (m_state == 1 && rise) m_state = 2;
            else if (m_state == 2 && empty && !keep) begin
                m_state = 0; m_busy = 0; m_fd = 1;
            end
            if (acc && !inb && m_clip < 65535) m_clip++;
            if (wr) void'(q.pop_front());
            if (keep) q.push_back('{int'(y) * 320 + int'(x), int'(cidx), cyc});
            dd_prev = draw_done;
            cyc++;
        end
    end

    initial forever begin
        @(posedge clk);
        if (rst_n && fb_we && fb_ready) begin dut_wr++; dut_last = int'(fb_addr); end
        if (rst_n && drawing && oe) dut_acc++;
    end

    initial forever begin
        @(negedge clk);
        check("oe", oe, m_oe());
        check("fb_we", fb_we, m_we());
        if (m_we()) begin
            check("fb_addr", fb_addr, q[0].a);
            check("fb_cidx", fb_cidx, q[0].c);
        end
        check("busy", busy, m_busy);
        check("flush_done", flush_done, m_fd);
        check("clip_cnt", clip_cnt, m_clip);
    end

    task automatic put(input int px, input int py, input int pc);
        @(negedge clk);
        drawing = 1'b1; x = 16'(px); y = 16'(py); cidx = 4'(pc);
    endtask

    task automatic wait_flush(input string name, input int lim);
        for (int i = 0; i < lim && !flush_done; i++) begin
            @(negedge clk);
            if (flush_done) break;
            fb_ready = ($urandom_range(0, 1) == 1) || lim < 50;
        end
        check(name, flush_done, 1);
        check({name, "_busy"}, busy, 0);
    endtask

    initial begin
        int w0, a0, t;
        int px[4] = '{-1, 320, 0, 319};
        int py[4] = '{5, 0, 180, 179};
        repeat (3) @(negedge clk);
        check("rst_fb_we", fb_we, 0);
        check("rst_oe", oe, 0);
        check("rst_addr", fb_addr, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1; fb_ready = 1'b1;

        put(160, 90, 2);
        @(negedge clk); drawing = 1'b0;
        check("t1_lat1", fb_we, 0);
        @(negedge clk);
        check("t1_we", fb_we, 1);
        check("t1_addr", fb_addr, 28960);
        check("t1_cidx", fb_cidx, 2);
        @(negedge clk); draw_done = 1'b1;
        wait_flush("t1_flush", 20);
        check("t1_clip", clip_cnt, 0);

        w0 = dut_wr;
        for (int i = 0; i < 4; i++) put(px[i], py[i], 1);
        @(negedge clk); drawing = 1'b0;
        repeat (5) @(negedge clk);
        check("t2_held_done_busy", busy, 1);
        check("t2_writes", dut_wr - w0, 1);
        check("t2_addr", dut_last, 57599);
        check("t2_clip", clip_cnt, 3);
        draw_done = 1'b0;
        @(negedge clk); draw_done = 1'b1;
        wait_flush("t2_flush", 20);
        draw_done = 1'b0;

        fb_ready = 1'b0; a0 = dut_acc; w0 = dut_wr;
        for (int i = 0; i < 20; i++) put(i, 1, 1);
        @(negedge clk); drawing = 1'b0;
        check("t3_accepts", dut_acc - a0, 7);
        check("t3_oe_low", oe, 0);
        fb_ready = 1'b1;
        repeat (12) @(negedge clk);
        check("t3_writes", dut_wr - w0, 7);
        check("t3_oe_high", oe, 1);
        draw_done = 1'b1;
        wait_flush("t3_flush", 20);
        draw_done = 1'b0;

        w0 = dut_wr;
        for (int i = 0; i < 5; i++) begin
            put(20 + i, 30, 5);
            fb_ready = $urandom_range(0, 1) == 1;
            draw_done = i == 4;
        end
        @(negedge clk); drawing = 1'b0;
        wait_flush("t4_flush", 100);
        check("t4_writes", dut_wr - w0, 5);
        draw_done = 1'b0; fb_ready = 1'b1;

        fb_ready = 1'b0;
        for (int i = 0; i < 5; i++) put(40 + i, 50, 6);
        @(negedge clk); drawing = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_queued", fb_we, 1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1 check("t5_async_we", fb_we, 0);
        check("t5_async_oe", oe, 0);
        @(negedge clk); fb_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        w0 = dut_wr;
        repeat (10) @(negedge clk);
        check("t5_no_writes", dut_wr - w0, 0);
        check("t5_idle", busy, 0);
        check("t5_oe", oe, 1);

        w0 = dut_wr;
        put(10, 10, 15);
        put(11, 10, 3);
        @(negedge clk); drawing = 1'b0;
        repeat (5) @(negedge clk);
`ifdef FB_SINK_TRANSPARENT_EN
        check("t6_writes", dut_wr - w0, 1);
`else
        check("t6_writes", dut_wr - w0, 2);
`endif
        check("t6_clip", clip_cnt, 0);
        draw_done = 1'b1;
        wait_flush("t6_flush", 20);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            drawing = $urandom_range(0, 3) != 0;
            t = int'($urandom_range(0, 360)) - 20; x = 16'(t);
            t = int'($urandom_range(0, 200)) - 10; y = 16'(t);
            cidx = 4'($urandom_range(0, 15));
            fb_ready = (i % 200 < 150) ? $urandom_range(0, 3) != 0 : $urandom_range(0, 7) == 0;
            if ($urandom_range(0, 49) == 0) draw_done = ~draw_done;
        end
        drawing = 1'b0; fb_ready = 1'b1;
        repeat (20) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
